// File: rtl/y86_pkg.sv
// Shared Y86 pipeline definitions: status codes, register indices, instruction codes.
package y86_pkg;

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;

    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t RNONE = 4'hF;
    localparam reg_idx_t RSP   = 4'd4;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_t;

endpackage

// File: rtl/wb_read_mux.sv
// One register-file read port: range check with zero fill, plus optional
// same-cycle forwarding of commit data when WB_REGFILE_BYPASS_EN is defined.
module wb_read_mux
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int IDX_W  = 4
) (
    input  logic [IDX_W-1:0]  src,
    input  logic [DATA_W-1:0] regs [NREG],
    input  logic              commit,
    input  logic [IDX_W-1:0]  dstE,
    input  logic [IDX_W-1:0]  dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic [DATA_W-1:0] val
);

    logic src_ok;
    assign src_ok = int'(src) < NREG;

`ifdef WB_REGFILE_BYPASS_EN
    logic m_hit;
    logic e_hit;
    // M is checked first so forwarding agrees with the M-wins write collision rule.
    assign m_hit = commit && (int'(dstM) < NREG) && (src == dstM);
    assign e_hit = commit && (int'(dstE) < NREG) && (src == dstE);

    always_comb begin
        val = '0;
        if (m_hit)
            val = valM;
        else if (e_hit)
            val = valE;
        else if (src_ok)
            val = regs[src];
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{commit, dstE, dstM, valE, valM};

    always_comb begin
        val = '0;
        if (src_ok)
            val = regs[src];
    end
`endif

endmodule

// File: rtl/wb_regfile.sv
// Y86 write-back register file: dual write (E/M), two read ports, halt latch,
// retire counter, debug port. Optional forwarding via WB_REGFILE_BYPASS_EN.
module wb_regfile
    import y86_pkg::*;
#(
    parameter int         DATA_W   = 64,
    parameter int         NREG     = 15,
    parameter int         IDX_W    = 4,
    parameter int         CNT_W    = 32,
    parameter logic [3:0] STAT_AOK = y86_pkg::STAT_AOK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_valid,
    input  logic [3:0]        w_stat,
    input  logic [IDX_W-1:0]  w_dstE,
    input  logic [IDX_W-1:0]  w_dstM,
    input  logic [DATA_W-1:0] w_valE,
    input  logic [DATA_W-1:0] w_valM,
    input  logic [IDX_W-1:0]  srcA,
    input  logic [IDX_W-1:0]  srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [IDX_W-1:0]  dbg_idx,
    output logic [DATA_W-1:0] dbg_data,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    logic [DATA_W-1:0] regs [NREG];
    logic commit;
    logic e_ok;
    logic m_ok;
    logic dbg_ok;

    assign commit = w_valid & ~halted & (w_stat == STAT_AOK);
    assign e_ok   = int'(w_dstE) < NREG;
    assign m_ok   = int'(w_dstM) < NREG;
    assign dbg_ok = int'(dbg_idx) < NREG;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++)
                regs[i] <= '0;
            dbg_data <= '0;
            halted   <= 1'b0;
            retired  <= '0;
        end else begin
            dbg_data <= dbg_ok ? regs[dbg_idx] : '0;
            if (commit) begin
                // M write follows E so it wins when both target the same register.
                if (e_ok)
                    regs[w_dstE] <= w_valE;
                if (m_ok)
                    regs[w_dstM] <= w_valM;
                retired <= retired + CNT_W'(1);
            end else if (w_valid && !halted) begin
                halted <= 1'b1;
            end
        end
    end

    wb_read_mux #(.DATA_W(DATA_W), .NREG(NREG), .IDX_W(IDX_W)) u_read_a (
        .src    (srcA),
        .regs   (regs),
        .commit (commit),
        .dstE   (w_dstE),
        .dstM   (w_dstM),
        .valE   (w_valE),
        .valM   (w_valM),
        .val    (valA)
    );

    wb_read_mux #(.DATA_W(DATA_W), .NREG(NREG), .IDX_W(IDX_W)) u_read_b (
        .src    (srcB),
        .regs   (regs),
        .commit (commit),
        .dstE   (w_dstE),
        .dstM   (w_dstM),
        .valE   (w_valE),
        .valM   (w_valM),
        .val    (valB)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic against an array-based reference model (counter width 4 to exercise wrap).
module tb_wb_regfile;

    localparam int DW = 64;
    localparam int NR = 15;
    localparam int IW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_valid;
    logic [3:0]    w_stat;
    logic [IW-1:0] w_dstE;
    logic [IW-1:0] w_dstM;
    logic [DW-1:0] w_valE;
    logic [DW-1:0] w_valM;
    logic [IW-1:0] srcA;
    logic [IW-1:0] srcB;
    logic [DW-1:0] valA;
    logic [DW-1:0] valB;
    logic [IW-1:0] dbg_idx;
    logic [DW-1:0] dbg_data;
    logic          halted;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    wb_regfile #(
        .DATA_W   (DW),
        .NREG     (NR),
        .IDX_W    (IW),
        .CNT_W    (CW),
        .STAT_AOK (4'd1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .w_valid  (w_valid),
        .w_stat   (w_stat),
        .w_dstE   (w_dstE),
        .w_dstM   (w_dstM),
        .w_valE   (w_valE),
        .w_valM   (w_valM),
        .srcA     (srcA),
        .srcB     (srcB),
        .valA     (valA),
        .valB     (valB),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data),
        .halted   (halted),
        .retired  (retired)
    );

    // Reference model state
    logic [DW-1:0] m_regs [NR];
    bit            m_halted;
    int            m_retired;
    bit            model_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] arr_read(input logic [3:0] idx);
        if (int'(idx) < NR)
            return m_regs[idx];
        return 64'd0;
    endfunction

    function automatic logic [63:0] port_read(input logic [3:0] idx);
`ifdef WB_REGFILE_BYPASS_EN
        bit cm;
        cm = w_valid && !m_halted && (w_stat == 4'd1);
        if (cm && int'(w_dstM) < NR && idx == w_dstM)
            return w_valM;
        if (cm && int'(w_dstE) < NR && idx == w_dstE)
            return w_valE;
`endif
        return arr_read(idx);
    endfunction

    task automatic drive(input bit r, input bit v, input logic [3:0] st,
                         input logic [3:0] dE, input logic [3:0] dM,
                         input logic [63:0] vE, input logic [63:0] vM,
                         input logic [3:0] sA, input logic [3:0] sB, input logic [3:0] dbg);
        rst = r; w_valid = v; w_stat = st;
        w_dstE = dE; w_dstM = dM; w_valE = vE; w_valM = vM;
        srcA = sA; srcB = sB; dbg_idx = dbg;
    endtask

    task automatic idle(input logic [3:0] sA, input logic [3:0] sB);
        drive(1'b0, 1'b0, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0, sA, sB, 4'd0);
    endtask

    // One clock: check read ports before the edge, advance the model, check registered outputs after.
    task automatic step();
        logic [63:0] exp_dbg;
        bit cm;
        #1;
        if (model_valid) begin
            chk("valA", valA, port_read(srcA));
            chk("valB", valB, port_read(srcB));
        end
        exp_dbg = rst ? 64'd0 : arr_read(dbg_idx);
        cm = w_valid && !m_halted && (w_stat == 4'd1);
        if (rst) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            m_halted  = 1'b0;
            m_retired = 0;
        end else if (cm) begin
            if (int'(w_dstE) < NR) m_regs[w_dstE] = w_valE;
            if (int'(w_dstM) < NR) m_regs[w_dstM] = w_valM;
            m_retired = (m_retired + 1) % (1 << CW);
        end else if (w_valid && !m_halted) begin
            m_halted = 1'b1;
        end
        @(posedge clk);
        #1;
        if (model_valid || rst) begin
            chk("dbg_data", dbg_data, exp_dbg);
            chk("halted", 64'(halted), 64'(m_halted));
            chk("retired", 64'(retired), 64'(m_retired));
        end
        if (rst) model_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0, 4'd0, 4'd0, 4'd0);
        step();
    endtask

    initial begin
        idle(4'd0, 4'd0);
        rst = 1'b1;
        @(negedge clk);

        // Reset, then every register reads zero
        do_reset();
        do_reset();
        for (int i = 0; i < NR; i++) begin
            drive(1'b0, 1'b0, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0, 4'(i), 4'(i), 4'(i));
            #1 chk("rst_read", valA, 64'd0);
            step();
        end
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);

        // Dual write
        drive(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 64'h11, 64'h22, 4'd0, 4'd0, 4'd0);
        step();
        idle(4'd2, 4'd3);
        #1;
        chk("dual_a", valA, 64'h11);
        chk("dual_b", valB, 64'h22);
        chk("dual_retired", 64'(retired), 64'd1);
        step();

        // Collision: M wins; RNONE leaves everything alone
        drive(1'b0, 1'b1, 4'd1, 4'd4, 4'd4, 64'h100, 64'h200, 4'd0, 4'd0, 4'd4);
        step();
        drive(1'b0, 1'b1, 4'd1, 4'hF, 4'hF, 64'hDEAD, 64'hBEEF, 4'd0, 4'd0, 4'd4);
        step();
        idle(4'd4, 4'hF);
        #1;
        chk("collision", valA, 64'h200);
        chk("rnone_read", valB, 64'd0);
        step();

        // Halt latch
        do_reset();
        drive(1'b0, 1'b1, 4'd1, 4'd1, 4'hF, 64'd5, 64'd0, 4'd1, 4'd0, 4'd1);
        step();
        drive(1'b0, 1'b1, 4'd2, 4'd1, 4'hF, 64'd9, 64'd0, 4'd1, 4'd0, 4'd1);
        step();
        chk("halt_set", 64'(halted), 64'd1);
        drive(1'b0, 1'b1, 4'd1, 4'd1, 4'hF, 64'd7, 64'd0, 4'd1, 4'd0, 4'd1);
        step();
        idle(4'd1, 4'd0);
        #1;
        chk("halt_reg1", valA, 64'd5);
        chk("halt_retired", 64'(retired), 64'd1);
        step();
        do_reset();
        idle(4'd1, 4'd0);
        #1 chk("halt_cleared", valA, 64'd0);
        step();

        // Same-cycle read of a register being committed
        drive(1'b0, 1'b1, 4'd1, 4'd6, 4'hF, 64'hAB, 64'd0, 4'd6, 4'd0, 4'd0);
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        chk("bypass", valA, 64'hAB);
`else
        chk("no_bypass", valA, 64'd0);
`endif
        step();

        // Counter wrap at 4 bits: 17 commits -> 1
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b1, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0, 4'd0, 4'd0, 4'd0);
            step();
        end
        chk("wrap", 64'(retired), 64'd1);

        // Reset overrides a simultaneous commit
        drive(1'b1, 1'b1, 4'd1, 4'd5, 4'd5, 64'h77, 64'h88, 4'd5, 4'd0, 4'd5);
        step();
        idle(4'd5, 4'd0);
        #1;
        chk("rst_commit_reg", valA, 64'd0);
        chk("rst_commit_ret", 64'(retired), 64'd0);
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] st;
            st = ($urandom_range(0, 99) < 4) ? 4'($urandom_range(0, 4)) : 4'd1;
            drive($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 80, st,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Parametrised successor to the pipeline's write-back register file.
- Sits at the end of the Y86 pipeline. It accepts the W-stage bundle and performs up to two register writes per cycle (E port and M port).
- Supplies two combinational read ports to decode.
- Adds synchronous reset, status-gated commit, a sticky halt latch, a retired-instruction counter and a debug read port.

Parameters:
- DATA_W, 64, register and data width in bits
- NREG, 15, number of architectural registers (indices 0..NREG-1)
- IDX_W, 4, register index width; index value 2**IDX_W-1 is RNONE
- CNT_W, 32, retired-instruction counter width
- STAT_AOK, 1, status code meaning normal execution

Ports:
- clk  in  1  clock, rising-edge active
- rst  in  1  synchronous active-high reset
- w_valid  in  1  W-stage bundle present this cycle
- w_stat  in  4  W-stage status code
- w_dstE  in  IDX_W  E-port destination; RNONE means no write
- w_dstM  in  IDX_W  M-port destination; RNONE means no write
- w_valE  in  DATA_W  E-port write data
- w_valM  in  DATA_W  M-port write data
- srcA  in  IDX_W  read port A index
- srcB  in  IDX_W  read port B index
- valA  out  DATA_W  read port A data (combinational)
- valB  out  DATA_W  read port B data (combinational)
- dbg_idx  in  IDX_W  debug read index
- dbg_data  out  DATA_W  debug read data (registered, 1-cycle latency)
- halted  out  1  sticky halt flag
- retired  out  CNT_W  count of committed instructions

Behaviour:
- Reset: on a rising clk edge with rst=1:
  - all NREG registers, dbg_data, halted and retired clear to 0
  - rst overrides every write or count in the same cycle
- Commit condition: commit = w_valid & ~halted & (w_stat == STAT_AOK).
- E-port write: when commit and w_dstE < NREG, regs[w_dstE] <= w_valE at the clk edge.
- M-port write: when commit and w_dstM < NREG, regs[w_dstM] <= w_valM.
- Out-of-range indices: RNONE or any index >= NREG cause no write and raise no error.
- Write collision: if w_dstE == w_dstM and both are valid, the M port wins (popq %rsp semantics).
- Halt latch:
  - w_valid & ~halted & (w_stat != STAT_AOK) sets halted at the next edge; that bundle's writes are suppressed.
  - halted stays set until rst; while halted, all writes and counting are blocked.
- Retire counter: retired increments by 1 on each commit edge and wraps modulo 2**CNT_W.
- Read ports: valA = regs[srcA] when srcA < NREG, otherwise 0. valB follows the same rule. Reads are pure combinational from the array.
- Debug port: dbg_data <= regs[dbg_idx] (0 if out of range) every edge; it shows the value before that edge's write.
- No X propagation: all outputs are defined from the first post-reset cycle.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN
- Defined: valA/valB forward same-cycle commit data.
  - If commit and srcA == w_dstM (valid), valA = w_valM.
  - Otherwise, if srcA == w_dstE (valid), valA = w_valE.
  - Otherwise valA reads the array. valB uses the same rule.
  - M-over-E priority matches the collision rule.
- Not defined: reads return only the pre-edge array contents; decode-side forwarding handles hazards.

Decomposition:
- Shared package y86_pkg holds:
  - STAT_AOK/HLT/ADR/INS = 1/2/3/4
  - RNONE = 4'hF, RSP = 4'd4
  - icode constants
  - the typedef reg_idx_t
- One sub-module, wb_read_mux, is natural. It contains range check, zero-fill and optional bypass, and is instantiated twice (A and B).
- Array, halt latch and counter stay in the top module.

Test Plan:
- Reset then read: rst for 2 cycles, read srcA=0..14 -> all 0; halted=0; retired=0.
- Dual write: commit with dstE=2 valE=0x11 and dstM=3 valM=0x22 -> next cycle valA(2)=0x11, valB(3)=0x22, retired=1.
- Collision: dstE=dstM=4, valE=0x100, valM=0x200 -> regs[4]=0x200. RNONE dst -> no change anywhere.
- Halt: after regs[1]=5, send stat=2 (HLT) with dstE=1 valE=9 -> regs[1] stays 5, halted=1. A later AOK bundle writing reg 1 -> still 5, retired unchanged. rst -> all cleared.
- Bypass (macro defined): commit dstE=6 valE=0xAB with srcA=6 in the same cycle -> valA=0xAB before the edge. Macro undefined -> valA=old value.
- Counter wrap with CNT_W=4: 17 commits -> retired=1. Reset asserted together with a commit -> regs unchanged from 0, retired=0.
